pe0_writeback: RTL and testbench
================================

PE0_WRITEBACK -- requirements
Module: pe0_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of the PE0 result word.
REQ-002 Parameter ADDR_WIDTH, default 7: coefficient-memory write address width.
REQ-003 Parameter LAT_NTT, default 4: cycles from issue to valid PE0_out, forward path (sel_1=0).
REQ-004 Parameter LAT_INTT, default 6: cycles from issue to valid PE0_out, inverse path (sel_1=1); LAT_INTT >= LAT_NTT >= 1.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse; opens a batch (honoured only in IDLE).
REQ-008 KD_mode  input  1  0 Kyber (two packed 12-bit lanes), 1 Dilithium (one 24-bit coefficient); latched at start.
REQ-009 sel_1  input  1  0 NTT, 1 INTT; latched at start; selects latency tap.
REQ-010 num_ops  input  8  number of issues in the batch; latched at start; 0 treated as 256.
REQ-011 issue_valid  input  1  an operand pair was presented to PE0 this cycle.
REQ-012 issue_addr  input  ADDR_WIDTH  write-back address for that operand pair.
REQ-013 PE0_out  input  DATA_WIDTH  PE0 result word.
REQ-014 wr_en  output  1  memory write strobe.
REQ-015 wr_addr  output  ADDR_WIDTH  memory write address.
REQ-016 wr_data  output  DATA_WIDTH  memory write data.
REQ-017 wr_kd  output  1  latched KD_mode, qualifies lane split at the memory.
REQ-018 busy  output  1  high in RUN and DRAIN.
REQ-019 done  output  1  one-cycle pulse when the last write of a batch retires.
REQ-020 err  output  1  sticky protocol-error flag.

Function
REQ-021 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN on the accepted issue that makes issued count equal num_ops; DRAIN->DONE on the cycle the final write is presented; DONE->IDLE unconditionally after one cycle.
REQ-022 start outside IDLE SHALL be ignored and SHALL set err.
REQ-023 issue_valid accepted only in RUN; in IDLE, DRAIN or DONE it SHALL be dropped and SHALL set err.
REQ-024 Each accepted issue SHALL enter a valid+address delay line of depth LAT_INTT; output tap = LAT_NTT or LAT_INTT per latched sel_1.
REQ-025 Issue accepted at edge t SHALL produce wr_en=1, wr_addr=issue_addr in exactly the cycle after edge t+LAT-1 (LAT cycles after issue), one write per issue, order preserved.
REQ-026 wr_data SHALL equal PE0_out when wr_en=1, and 0 otherwise; no additional register stage.
REQ-027 Back-to-back issues every cycle SHALL be supported with no bubbles and no drops.
REQ-028 Issued and retired counters SHALL be 9 bits so that num_ops=0 (256) does not wrap.
REQ-029 done SHALL assert in the DONE cycle, i.e. the cycle after the final wr_en.
REQ-030 Latched KD_mode, sel_1, num_ops SHALL not change between start and DONE; input changes mid-batch have no effect.
REQ-031 Same-cycle start and issue_valid in IDLE: start honoured, issue dropped, err set.

Reset
REQ-032 rst SHALL force IDLE, clear delay line and counters, and drive wr_en=0, wr_addr=0, wr_data=0, wr_kd=0, busy=0, done=0, err=0 on the following cycle.
REQ-033 rst mid-batch SHALL discard in-flight writes; no wr_en after the reset edge.
REQ-034 err SHALL clear only on rst.

Verification
REQ-035 NTT, KD_mode=0, num_ops=4, issues addr 0..3 consecutive cycles from cycle 1 -> wr_en cycles 5..8, wr_addr 0..3, done at cycle 9, err=0.
REQ-036 INTT, KD_mode=1, num_ops=2, issues addr 10 at cycle 1 and 20 at cycle 4 -> writes at cycles 7 and 10, done at cycle 11, wr_kd=1.
REQ-037 num_ops=0, 256 consecutive issues -> 256 writes, busy stays high throughout, single done pulse.
REQ-038 issue_valid in IDLE, then start during RUN -> no write, err=1 sticky, batch completes normally.
REQ-039 rst asserted 2 cycles after 3 issues in NTT -> no wr_en afterwards, busy=0, done never pulses.
REQ-040 sel_1 toggled mid-batch (started NTT) -> all writes still at LAT_NTT latency.

Source files
------------

// File: rtl/pe0_writeback_if.sv
// PE0 write-back bundle: batch control, issue tracking, PE0 result and memory write port.
interface pe0_writeback_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic                  KD_mode;
  logic                  sel_1;
  logic [7:0]            num_ops;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] PE0_out;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_kd;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, KD_mode, sel_1, num_ops, issue_valid, issue_addr, PE0_out,
    input  wr_en, wr_addr, wr_data, wr_kd, busy, done, err
  );

  modport slave (
    input  start, KD_mode, sel_1, num_ops, issue_valid, issue_addr, PE0_out,
    output wr_en, wr_addr, wr_data, wr_kd, busy, done, err
  );
endinterface

// File: rtl/pe0_writeback.sv
// Tracks PE0 issues through a latency-matched delay line and turns each into one
// coefficient-memory write; batches are framed by start/num_ops.
module pe0_writeback #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 7,
  parameter int LAT_NTT    = 4,
  parameter int LAT_INTT   = 6
) (
  input logic          clk,
  input logic          rst,
  pe0_writeback_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  kd_q, kd_d, sel_q, sel_d, err_q, err_d;
  logic [7:0]            num_q, num_d;
  logic [8:0]            issued_q, issued_d, retired_q, retired_d, total;
  logic [LAT_INTT-1:0]   vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q [LAT_INTT];
  logic [ADDR_WIDTH-1:0] addr_d [LAT_INTT];
  logic                  start_acc, issue_acc, tap_vld;
  logic [ADDR_WIDTH-1:0] tap_addr;
  logic [DATA_WIDTH-1:0] wr_data_c;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kd_q      <= 1'b0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
      num_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      vld_q     <= '0;
      for (int unsigned i = 0; i < LAT_INTT; i++) addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      kd_q      <= kd_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      vld_q     <= vld_d;
      addr_q    <= addr_d;
    end
  end

  // Datapath next-state
  always_comb begin
    start_acc = (state_q == S_IDLE) && bus.start;
    issue_acc = (state_q == S_RUN) && bus.issue_valid;
    total     = (num_q == 8'd0) ? 9'd256 : {1'b0, num_q};
    tap_vld   = sel_q ? vld_q[LAT_INTT-1]  : vld_q[LAT_NTT-1];
    tap_addr  = sel_q ? addr_q[LAT_INTT-1] : addr_q[LAT_NTT-1];

    vld_d[0]  = issue_acc;
    addr_d[0] = bus.issue_addr;
    for (int unsigned i = 1; i < LAT_INTT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end

    kd_d      = start_acc ? bus.KD_mode : kd_q;
    sel_d     = start_acc ? bus.sel_1   : sel_q;
    num_d     = start_acc ? bus.num_ops : num_q;
    issued_d  = start_acc ? 9'd0 : issued_q  + {8'd0, issue_acc};
    retired_d = start_acc ? 9'd0 : retired_q + {8'd0, tap_vld};
    err_d     = err_q
              | (bus.start && (state_q != S_IDLE))
              | (bus.issue_valid && (state_q != S_RUN));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (issue_acc && (issued_q + 9'd1 == total)) state_d = S_DRAIN;
      S_DRAIN: if (tap_vld && (retired_q + 9'd1 == total)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: write port is combinational off the selected tap
  always_comb begin
    wr_data_c   = tap_vld ? bus.PE0_out : '0;
    bus.wr_en   = tap_vld;
    bus.wr_addr = tap_vld ? tap_addr : '0;
    bus.wr_data = wr_data_c;
    bus.wr_kd   = kd_q;
    bus.busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    bus.done    = (state_q == S_DONE);
    bus.err     = err_q;
  end

endmodule

// File: tb/tb_pe0_writeback.sv
// Randomized batches against a cycle-indexed expectation table and a write queue.
module tb_pe0_writeback;
  localparam int DW = 24;
  localparam int AW = 7;
  localparam int LN = 4;
  localparam int LI = 6;
  localparam int NCYC = 8192;

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    bit          kd;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [DW-1:0] pe0_drv = '0;

  wr_t exp_q[$];
  bit  exp_busy [NCYC];
  bit  exp_done [NCYC];
  bit  exp_err  [NCYC];

  pe0_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pe0_writeback #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAT_NTT(LN), .LAT_INTT(LI)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic mark_err(input int c);
    for (int k = c + 1; k < NCYC; k++) exp_err[k] = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = AW'($urandom);
    pe0_drv         = DW'($urandom);
    bus.PE0_out     = pe0_drv;
  endtask

  // Monitor: every cycle compare write port and status against expectations
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_en",   32'(bus.wr_en), 32'd1);
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.wr_data), 32'(pe0_drv));
        chk("wr_kd",   32'(bus.wr_kd), 32'(e.kd));
      end else begin
        chk("wr_en_idle",   32'(bus.wr_en), 32'd0);
        chk("wr_data_idle", 32'(bus.wr_data), 32'd0);
      end
      chk("busy", 32'(bus.busy), 32'(exp_busy[cyc]));
      chk("done", 32'(bus.done), 32'(exp_done[cyc]));
      chk("err",  32'(bus.err),  32'(exp_err[cyc]));
    end
  end

  // One full batch; n=0 means 256 issues
  task automatic run_batch(input bit kd, input bit sel, input int n, input int pct,
                           input bit inj_start, input bit inj_issue, input bit toggle);
    int s, total, cnt, lat, last_w;
    bit injected;
    next_cycle();
    s = cyc;
    bus.start   = 1'b1;
    bus.KD_mode = kd;
    bus.sel_1   = sel;
    bus.num_ops = 8'(n);
    if (inj_issue) begin
      bus.issue_valid = 1'b1;
      mark_err(s);
    end
    total    = (n == 0) ? 256 : n;
    lat      = sel ? LI : LN;
    cnt      = 0;
    last_w   = 0;
    injected = 1'b0;
    while (cnt < total) begin
      next_cycle();
      exp_busy[cyc] = 1'b1;
      if (toggle) begin
        bus.sel_1   = ~bus.sel_1;
        bus.KD_mode = 1'($urandom);
        bus.num_ops = 8'($urandom);
      end
      if (inj_start && !injected && cnt >= 1) begin
        bus.start = 1'b1;
        injected  = 1'b1;
        mark_err(cyc);
      end
      if ($urandom_range(99) < 32'(pct)) begin
        bus.issue_valid = 1'b1;
        exp_q.push_back('{cyc: cyc + lat, addr: bus.issue_addr, kd: kd});
        last_w = cyc + lat;
        cnt++;
      end
    end
    exp_done[last_w + 1] = 1'b1;
    while (cyc < last_w) begin
      next_cycle();
      exp_busy[cyc] = 1'b1;
    end
    next_cycle();
  endtask

  // Three issues, two idle cycles, then reset in the middle of the batch
  task automatic reset_mid();
    int s, r;
    next_cycle();
    s = cyc;
    bus.start   = 1'b1;
    bus.KD_mode = 1'b1;
    bus.sel_1   = 1'b0;
    bus.num_ops = 8'd8;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      exp_busy[cyc] = 1'b1;
      if (i < 3) begin
        bus.issue_valid = 1'b1;
        exp_q.push_back('{cyc: cyc + LN, addr: bus.issue_addr, kd: 1'b1});
      end
    end
    next_cycle();
    exp_busy[cyc] = 1'b1;
    r = cyc;
    rst = 1'b1;
    for (int k = exp_q.size() - 1; k >= 0; k--)
      if (exp_q[k].cyc > r) exp_q.delete(k);
    for (int k = r + 1; k < NCYC; k++) exp_err[k] = 1'b0;
    next_cycle();
    rst = 1'b0;
    chk("rst_wr_kd",   32'(bus.wr_kd), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    for (int i = 0; i < 8; i++) next_cycle();
    chk("rst_no_done_seen", 32'(s), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.KD_mode = 1'b0; bus.sel_1 = 1'b0; bus.num_ops = '0;
    bus.issue_valid = 1'b0; bus.issue_addr = '0; bus.PE0_out = '0;
    for (int k = 0; k < NCYC; k++) begin
      exp_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    chk("reset_wr_kd",   32'(bus.wr_kd), 32'd0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    next_cycle();

    run_batch(1'b0, 1'b0, 4, 100, 1'b0, 1'b0, 1'b0);   // NTT, Kyber, back-to-back
    run_batch(1'b1, 1'b1, 2, 35,  1'b0, 1'b0, 1'b0);   // INTT, Dilithium, gaps
    run_batch(1'b0, 1'b0, 6, 60,  1'b1, 1'b1, 1'b0);   // idle issue + start in RUN
    run_batch(1'b0, 1'b0, 12, 70, 1'b0, 1'b0, 1'b1);   // inputs toggled mid-batch
    for (int b = 0; b < 10; b++)
      run_batch(1'($urandom), 1'($urandom), int'($urandom_range(1, 40)),
                int'($urandom_range(30, 100)), (b % 3) == 0, (b % 4) == 1, (b % 2) == 0);
    reset_mid();
    run_batch(1'b1, 1'b0, 5, 80, 1'b0, 1'b0, 1'b0);
    run_batch(1'b1, 1'b1, 0, 100, 1'b0, 1'b0, 1'b0);   // 256 issues
    for (int i = 0; i < 10; i++) next_cycle();
    chk("leftover_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
